// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: byte-wide memory read port, jump request from control,
// and the valid/ready instruction port towards the decoder.
interface fetch_unit_if #(
  parameter int INST_SIZE = 16,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
);
  logic                 mem_rd;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_rdata;
  logic                 mem_ack;
  logic                 pc_load;
  logic [ADDR_BITS-1:0] pc_target;
  logic [INST_SIZE-1:0] inst;
  logic [ADDR_BITS-1:0] inst_pc;
  logic                 inst_valid;
  logic                 inst_ready;

  modport master (
    output mem_rd, mem_addr, inst, inst_pc, inst_valid,
    input  mem_rdata, mem_ack, pc_load, pc_target, inst_ready
  );

  modport slave (
    input  mem_rd, mem_addr, inst, inst_pc, inst_valid,
    output mem_rdata, mem_ack, pc_load, pc_target, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// OrgaSmall instruction fetch: two big-endian byte reads per instruction,
// valid/ready hand-off to the decoder, PC increment and jump redirect with flush.
module fetch_unit #(
  parameter int INST_SIZE = 16,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_HI, S_LO, S_HOLD} state_t;

  localparam logic [ADDR_BITS-1:0] PC_STEP = ADDR_BITS'(2);

  state_t               state_q;
  logic [ADDR_BITS-1:0] pc_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 flush_q;
  logic [INST_SIZE-1:0] inst_q;
  logic [ADDR_BITS-1:0] inst_pc_q;
  logic                 inst_valid_q;

  // addr_q keeps the address of the outstanding request, so a jump that lands
  // mid-transaction changes pc_q without disturbing the memory port.
  assign bus.mem_rd     = rst_n && (state_q != S_HOLD);
  assign bus.mem_addr   = addr_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_HI;
      pc_q         <= '0;
      addr_q       <= '0;
      flush_q      <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_HI, S_LO: begin
          if (bus.pc_load) pc_q <= bus.pc_target;
          if (bus.mem_ack) begin
            if (bus.pc_load || flush_q) begin
              // Completed request belongs to the abandoned stream: drop it.
              flush_q <= 1'b0;
              state_q <= S_HI;
              addr_q  <= bus.pc_load ? bus.pc_target : pc_q;
            end else if (state_q == S_HI) begin
              inst_q[INST_SIZE-1:DATA_BITS] <= bus.mem_rdata;
              addr_q  <= addr_q + 1'b1;
              state_q <= S_LO;
            end else begin
              inst_q[DATA_BITS-1:0] <= bus.mem_rdata;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
              state_q      <= S_HOLD;
            end
          end else if (bus.pc_load) begin
            flush_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.pc_load) begin
            inst_valid_q <= 1'b0;
            pc_q         <= bus.pc_target;
            addr_q       <= bus.pc_target;
            state_q      <= S_HI;
          end else if (bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            pc_q         <= pc_q + PC_STEP;
            addr_q       <= pc_q + PC_STEP;
            state_q      <= S_HI;
          end
        end
        default: state_q <= S_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural byte memory with programmable
// wait states, checks sampled 1 time unit after each rising edge.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.INST_SIZE(16), .DATA_BITS(8), .ADDR_BITS(8)) bus ();

  fetch_unit #(.INST_SIZE(16), .DATA_BITS(8), .ADDR_BITS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  logic [7:0] mem [0:255];
  int         wait_n = 0;
  int         ack_cnt = 0;
  logic       force_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  always_comb begin
    bus.mem_ack   = force_ack || (bus.mem_rd && (ack_cnt >= wait_n));
    bus.mem_rdata = mem[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (!bus.mem_rd || bus.mem_ack) ack_cnt <= 0;
    else                            ack_cnt <= ack_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, output int cycles);
    cycles = 0;
    while (bus.inst_valid !== 1'b1 && cycles < max_cycles) begin
      step();
      cycles++;
    end
    if (bus.inst_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_valid timeout observed=0 expected=1");
    end
  endtask

  int n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
    mem[3] = 8'hD4; mem[4] = 8'hE5; mem[5] = 8'hF6;
    mem[8'h40] = 8'h9A; mem[8'h41] = 8'hBC;
    bus.pc_load    = 1'b0;
    bus.pc_target  = 8'h00;
    bus.inst_ready = 1'b1;

    // Reset and sequential zero-wait fetch
    rst_n = 1'b0;
    step();
    step();
    chk("rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_valid", 32'(bus.inst_valid), 0);
    chk("rst_inst", 32'(bus.inst), 0);
    chk("rst_inst_pc", 32'(bus.inst_pc), 0);
    rst_n = 1'b1;
    #1;
    chk("seq_first_rd", 32'(bus.mem_rd), 1);
    chk("seq_first_addr", 32'(bus.mem_addr), 0);
    step();
    chk("seq_lo_addr", 32'(bus.mem_addr), 1);
    chk("seq_lo_valid", 32'(bus.inst_valid), 0);
    step();
    chk("seq_w0_valid", 32'(bus.inst_valid), 1);
    chk("seq_w0_inst", 32'(bus.inst), 32'hA1B2);
    chk("seq_w0_pc", 32'(bus.inst_pc), 0);
    chk("seq_hold_rd", 32'(bus.mem_rd), 0);
    step();
    chk("seq_w1_addr", 32'(bus.mem_addr), 2);
    chk("seq_w1_gap", 32'(bus.inst_valid), 0);
    step();
    step();
    chk("seq_w1_valid", 32'(bus.inst_valid), 1);
    chk("seq_w1_inst", 32'(bus.inst), 32'hC3D4);
    chk("seq_w1_pc", 32'(bus.inst_pc), 2);
    step();
    step();
    chk("seq_w2_gap", 32'(bus.inst_valid), 0);
    step();
    chk("seq_w2_inst", 32'(bus.inst), 32'hE5F6);
    chk("seq_w2_pc", 32'(bus.inst_pc), 4);

    // Two wait states per byte: 7 cycles per instruction
    wait_n = 2;
    do_reset();
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("ws_rd", 32'(bus.mem_rd), 1);
      chk("ws_addr", 32'(bus.mem_addr), (i < 3) ? 0 : 1);
      chk("ws_valid", 32'(bus.inst_valid), 0);
      step();
    end
    chk("ws_w0_inst", 32'(bus.inst), 32'hA1B2);
    chk("ws_w0_valid", 32'(bus.inst_valid), 1);
    for (int i = 0; i < 7; i++) step();
    chk("ws_w1_valid", 32'(bus.inst_valid), 1);
    chk("ws_w1_inst", 32'(bus.inst), 32'hC3D4);
    chk("ws_w1_pc", 32'(bus.inst_pc), 2);

    // Backpressure holds the word and idles the memory port
    wait_n = 0;
    bus.inst_ready = 1'b0;
    do_reset();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.inst_valid), 1);
      chk("bp_inst", 32'(bus.inst), 32'hA1B2);
      chk("bp_rd", 32'(bus.mem_rd), 0);
      step();
    end
    bus.inst_ready = 1'b1;
    step();
    chk("bp_next_rd", 32'(bus.mem_rd), 1);
    chk("bp_next_addr", 32'(bus.mem_addr), 2);
    chk("bp_next_valid", 32'(bus.inst_valid), 0);

    // Jump while the low-byte request is pending: flush
    wait_n = 3;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("jf_lo_pending", 32'(bus.mem_addr), 1);
    bus.pc_load = 1'b1;
    bus.pc_target = 8'h40;
    step();
    bus.pc_load = 1'b0;
    chk("jf_addr_hold1", 32'(bus.mem_addr), 1);
    chk("jf_rd_hold1", 32'(bus.mem_rd), 1);
    step();
    chk("jf_addr_hold2", 32'(bus.mem_addr), 1);
    step();
    chk("jf_no_valid", 32'(bus.inst_valid), 0);
    chk("jf_new_addr", 32'(bus.mem_addr), 32'h40);
    wait_valid(30, n);
    chk("jf_latency", 32'(n), 8);
    chk("jf_inst", 32'(bus.inst), 32'h9ABC);
    chk("jf_pc", 32'(bus.inst_pc), 32'h40);

    // Wrap-around: jump to 0xFF, then 0xFE, next fetch after 0xFE is 0x00
    mem[8'hFE] = 8'h56; mem[8'hFF] = 8'h12; mem[8'h00] = 8'h34;
    wait_n = 0;
    bus.inst_ready = 1'b0;
    do_reset();
    bus.pc_load = 1'b1;
    bus.pc_target = 8'hFF;
    step();
    bus.pc_load = 1'b0;
    chk("wr_ff_addr", 32'(bus.mem_addr), 32'hFF);
    step();
    chk("wr_lo_addr", 32'(bus.mem_addr), 0);
    step();
    chk("wr_ff_valid", 32'(bus.inst_valid), 1);
    chk("wr_ff_inst", 32'(bus.inst), 32'h1234);
    chk("wr_ff_pc", 32'(bus.inst_pc), 32'hFF);
    bus.pc_load = 1'b1;
    bus.pc_target = 8'hFE;
    step();
    bus.pc_load = 1'b0;
    chk("wr_fe_drop", 32'(bus.inst_valid), 0);
    chk("wr_fe_addr", 32'(bus.mem_addr), 32'hFE);
    step();
    step();
    chk("wr_fe_inst", 32'(bus.inst), 32'h5612);
    chk("wr_fe_pc", 32'(bus.inst_pc), 32'hFE);
    bus.inst_ready = 1'b1;
    step();
    chk("wr_next_addr", 32'(bus.mem_addr), 0);
    chk("wr_next_rd", 32'(bus.mem_rd), 1);

    // Reset while waiting in the low-byte fetch; late ack ignored
    wait_n = 3;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("rm_pending", 32'(bus.mem_addr), 1);
    rst_n = 1'b0;
    step();
    force_ack = 1'b1;
    #1;
    chk("rm_rd_low", 32'(bus.mem_rd), 0);
    step();
    force_ack = 1'b0;
    wait_n = 0;
    rst_n = 1'b1;
    #1;
    chk("rm_valid", 32'(bus.inst_valid), 0);
    chk("rm_restart_addr", 32'(bus.mem_addr), 0);
    step();
    step();
    chk("rm_inst", 32'(bus.inst), 32'h34B2);
    chk("rm_pc", 32'(bus.inst_pc), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
